ldm_stm_sequencer: RTL and testbench

- Multi-cycle sequencer for ARMv4 block transfers (LDM/STM).
- Walks a 16-bit register list and produces one word access per set bit. It is the producer side of the register file: it drives the read-port code for STM store data and drives WB-phase writes for LDM results.
- Drives base-register writeback on the EX-phase write port.
- Sits in the EX/MEM stage between the decoder, the register file and the data memory interface.

---
 rtl/ldm_stm_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list, issues one word
// access per set bit, and produces load write-backs and base-register writeback.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_load,
  input  logic              i_pre,
  input  logic              i_up,
  input  logic              i_wback,
  input  logic [3:0]        i_rn_code,
  input  logic [DATA_W-1:0] i_rn_reg,
  input  logic [15:0]       i_reg_list,
  output logic [3:0]        o_rm_code,
  input  logic [DATA_W-1:0] i_rm_reg,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rd_en_wb,
  output logic [3:0]        o_rd_code_wb,
  output logic [DATA_W-1:0] o_rd_reg_wb,
  output logic              o_rd_en_ex,
  output logic [3:0]        o_rd_code_ex,
  output logic [DATA_W-1:0] o_rd_reg_ex,
  output logic              o_busy,
  output logic              o_done
);

  // state | meaning
  // IDLE  | waiting for i_start; fields are sampled here only
  // XFER  | one access per pending list bit, lowest register first
  // FIN   | done pulse, base writeback, last load write lands here
  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t            state_q, state_d;
  logic [15:0]       mask_q;
  logic              load_q;
  logic [3:0]        rn_q;
  logic              wb_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] final_q;
  logic              rd_en_wb_q;
  logic [3:0]        rd_code_wb_q;
  logic [DATA_W-1:0] rd_reg_wb_q;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < 16; k++) c = c + 5'(v[k]);
    return c;
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int k = 15; k >= 0; k--) if (v[k]) r = 4'(k);
    return r;
  endfunction

  logic [4:0]        cnt;
  logic [ADDR_W-1:0] span, base, start_addr, final_addr;
  logic [3:0]        cur_code;
  logic [15:0]       mask_next;
  logic              ack_x;

  always_comb begin
    cnt   = popcount16(i_reg_list);
    span  = ADDR_W'({cnt, 2'b00});
    base  = ADDR_W'(i_rn_reg);
    case ({i_pre, i_up})
      2'b01:   start_addr = base;
      2'b11:   start_addr = base + ADDR_W'(4);
      2'b00:   start_addr = base - span + ADDR_W'(4);
      default: start_addr = base - span;
    endcase
    final_addr = i_up ? (base + span) : (base - span);
    cur_code   = lowest_bit(mask_q);
    // Clearing the lowest set bit walks the list in ascending register order.
    mask_next  = mask_q & (mask_q - 16'd1);
    ack_x      = (state_q == XFER) && i_mem_ack;
  end

  always_comb begin
    state_d      = state_q;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_rm_code    = '0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_rd_en_ex   = 1'b0;
    o_rd_code_ex = '0;
    o_rd_reg_ex  = '0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = (i_reg_list == 16'd0) ? FIN : XFER;
      end
      XFER: begin
        o_mem_req  = 1'b1;
        o_mem_we   = !load_q;
        o_mem_addr = addr_q;
        o_rm_code  = cur_code;
        o_busy     = 1'b1;
        if (i_mem_ack && (mask_next == 16'd0)) state_d = FIN;
      end
      FIN: begin
        o_done     = 1'b1;
        o_busy     = 1'b1;
        o_rd_en_ex = wb_en_q;
        if (wb_en_q) begin
          o_rd_code_ex = rn_q;
          o_rd_reg_ex  = final_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_mem_wdata  = i_rm_reg;
  assign o_rd_en_wb   = rd_en_wb_q;
  assign o_rd_code_wb = rd_en_wb_q ? rd_code_wb_q : 4'd0;
  assign o_rd_reg_wb  = rd_en_wb_q ? rd_reg_wb_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      load_q       <= 1'b0;
      rn_q         <= '0;
      wb_en_q      <= 1'b0;
      addr_q       <= '0;
      final_q      <= '0;
      rd_en_wb_q   <= 1'b0;
      rd_code_wb_q <= '0;
      rd_reg_wb_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_wb_q <= ack_x && load_q;
      if (ack_x) begin
        mask_q <= mask_next;
        addr_q <= addr_q + ADDR_W'(4);
        if (load_q) begin
          rd_code_wb_q <= cur_code;
          rd_reg_wb_q  <= i_mem_rdata;
        end
      end
      if ((state_q == IDLE) && i_start) begin
        mask_q  <= i_reg_list;
        load_q  <= i_load;
        rn_q    <= i_rn_code;
        addr_q  <= start_addr;
        final_q <= DATA_W'(final_addr);
        // A loaded base register takes priority over the writeback value.
        wb_en_q <= i_wback && (i_reg_list != 16'd0) && !(i_load && i_reg_list[i_rn_code]);
      end
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed block transfers, expected
// accesses/writes queued at issue time and checked by an independent monitor.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_load, i_pre, i_up, i_wback;
  logic [3:0]  i_rn_code;
  logic [31:0] i_rn_reg;
  logic [15:0] i_reg_list;
  logic [3:0]  o_rm_code;
  logic [31:0] i_rm_reg;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata;
  logic        o_rd_en_wb, o_rd_en_ex, o_busy, o_done;
  logic [3:0]  o_rd_code_wb, o_rd_code_ex;
  logic [31:0] o_rd_reg_wb, o_rd_reg_ex;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_load(i_load), .i_pre(i_pre),
    .i_up(i_up), .i_wback(i_wback), .i_rn_code(i_rn_code), .i_rn_reg(i_rn_reg),
    .i_reg_list(i_reg_list), .o_rm_code(o_rm_code), .i_rm_reg(i_rm_reg),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_rd_en_wb(o_rd_en_wb), .o_rd_code_wb(o_rd_code_wb), .o_rd_reg_wb(o_rd_reg_wb),
    .o_rd_en_ex(o_rd_en_ex), .o_rd_code_ex(o_rd_code_ex), .o_rd_reg_ex(o_rd_reg_ex),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Register-file and memory stand-ins.
  assign i_rm_reg    = 32'h5000_0000 | {28'h0, o_rm_code};
  assign i_mem_rdata = {16'hA0A0, 8'h00, o_mem_addr[7:0]};

  typedef struct {logic [31:0] addr; logic we; logic [3:0] code;} mem_t;
  typedef struct {logic [3:0] code; logic [31:0] data;} wr_t;
  mem_t mem_q[$];
  wr_t  wb_q[$];
  wr_t  ex_q[$];
  int   done_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, start_cyc = 0;
  int done_seen = 0, ack_seen = 0, ops = 0;
  int ack_delay = 0, wait_cnt = 0;
  bit force_ack = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (force_ack) i_mem_ack = 1'b1;
    else if (o_mem_req) begin
      if (wait_cnt >= ack_delay) begin
        i_mem_ack = 1'b1;
        wait_cnt  = 0;
      end else begin
        i_mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
      wait_cnt  = 0;
    end
  end

  always @(negedge clk) begin : monitor
    mem_t m;
    wr_t  w;
    int   lat;
    if (rst_n) begin
      if (o_mem_req) begin
        if (mem_q.size() == 0) check("unexpected_req", 64'(o_mem_req), 64'd0);
        else begin
          m = mem_q[0];
          check("mem_addr", 64'(o_mem_addr), 64'(m.addr));
          check("mem_we", 64'(o_mem_we), 64'(m.we));
          check("rm_code", 64'(o_rm_code), 64'(m.code));
          if (m.we) check("mem_wdata", 64'(o_mem_wdata), 64'(32'h5000_0000 | {28'h0, m.code}));
          if (i_mem_ack) begin
            void'(mem_q.pop_front());
            ack_seen++;
          end
        end
      end
      if (o_rd_en_wb) begin
        if (wb_q.size() == 0) check("unexpected_wb", 64'(o_rd_en_wb), 64'd0);
        else begin
          w = wb_q.pop_front();
          check("wb_code", 64'(o_rd_code_wb), 64'(w.code));
          check("wb_data", 64'(o_rd_reg_wb), 64'(w.data));
        end
      end
      if (o_rd_en_ex) begin
        if (ex_q.size() == 0) check("unexpected_ex", 64'(o_rd_en_ex), 64'd0);
        else begin
          w = ex_q.pop_front();
          check("ex_code", 64'(o_rd_code_ex), 64'(w.code));
          check("ex_data", 64'(o_rd_reg_ex), 64'(w.data));
        end
      end
      if (o_done) begin
        if (done_q.size() == 0) check("unexpected_done", 64'(o_done), 64'd0);
        else begin
          lat = done_q.pop_front();
          check("done_busy", 64'(o_busy), 64'd1);
          check("done_req", 64'(o_mem_req), 64'd0);
          if (lat >= 0) check("done_latency", 64'(cyc - start_cyc), 64'(lat));
          done_seen++;
        end
      end
    end
  end

  task automatic exp_mem(input logic [31:0] a, input logic we, input logic [3:0] c);
    mem_t m;
    m.addr = a; m.we = we; m.code = c;
    mem_q.push_back(m);
  endtask

  task automatic exp_wb(input logic [3:0] c, input logic [31:0] d);
    wr_t w;
    w.code = c; w.data = d;
    wb_q.push_back(w);
  endtask

  task automatic exp_ex(input logic [3:0] c, input logic [31:0] d);
    wr_t w;
    w.code = c; w.data = d;
    ex_q.push_back(w);
  endtask

  task automatic start_op(input logic ld, input logic pre, input logic up, input logic wb,
                          input logic [3:0] rn, input logic [31:0] b, input logic [15:0] list);
    @(posedge clk); #1;
    i_load = ld; i_pre = pre; i_up = up; i_wback = wb;
    i_rn_code = rn; i_rn_reg = b; i_reg_list = list;
    i_start = 1'b1;
    start_cyc = cyc;
    ops++;
    @(posedge clk); #1;
    i_start = 1'b0;
    // Scramble fields: the sequencer must not look at them after start.
    i_load = ~ld; i_pre = ~pre; i_up = ~up; i_wback = ~wb;
    i_rn_code = ~rn; i_rn_reg = 32'hDEAD_BEEF; i_reg_list = 16'hFFFF;
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    while (done_seen < ops && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    check({name, "_completed"}, 64'(done_seen), 64'(ops));
    check({name, "_mem_drained"}, 64'(mem_q.size()), 64'd0);
    check({name, "_wb_drained"}, 64'(wb_q.size()), 64'd0);
    check({name, "_ex_drained"}, 64'(ex_q.size()), 64'd0);
    done_seen = ops;
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 64'(o_mem_req), 64'd0);
    check("rst_we", 64'(o_mem_we), 64'd0);
    check("rst_addr", 64'(o_mem_addr), 64'd0);
    check("rst_rm_code", 64'(o_rm_code), 64'd0);
    check("rst_rd_en_wb", 64'(o_rd_en_wb), 64'd0);
    check("rst_rd_code_wb", 64'(o_rd_code_wb), 64'd0);
    check("rst_rd_en_ex", 64'(o_rd_en_ex), 64'd0);
    check("rst_rd_code_ex", 64'(o_rd_code_ex), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
  endtask

  initial begin
    int guard, base_ack;
    rst_n = 1'b0; i_start = 1'b0; i_load = 1'b0; i_pre = 1'b0; i_up = 1'b0;
    i_wback = 1'b0; i_rn_code = 4'd0; i_rn_reg = 32'd0; i_reg_list = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // STM IA, three registers, constant ack
    exp_mem(32'h1000, 1'b1, 4'd0);
    exp_mem(32'h1004, 1'b1, 4'd1);
    exp_mem(32'h1008, 1'b1, 4'd4);
    exp_ex(4'd5, 32'h100C);
    done_q.push_back(4);
    start_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h1000, 16'h0013);
    wait_done("stm_ia");

    // LDM DB including r15
    exp_mem(32'h1FF4, 1'b0, 4'd1);
    exp_mem(32'h1FF8, 1'b0, 4'd2);
    exp_mem(32'h1FFC, 1'b0, 4'd15);
    exp_wb(4'd1, 32'hA0A0_00F4);
    exp_wb(4'd2, 32'hA0A0_00F8);
    exp_wb(4'd15, 32'hA0A0_00FC);
    exp_ex(4'd13, 32'h1FF4);
    done_q.push_back(4);
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h2000, 16'h8006);
    wait_done("ldm_db");

    // LDM IB, base in list, slow memory
    ack_delay = 3;
    exp_mem(32'h3004, 1'b0, 4'd3);
    exp_wb(4'd3, 32'hA0A0_0004);
    done_q.push_back(-1);
    start_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 32'h3000, 16'h0008);
    wait_done("ldm_ib_slow");
    ack_delay = 0;

    // Empty list
    done_q.push_back(1);
    start_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h4000, 16'h0000);
    wait_done("empty");

    // Reset after two of four acks
    base_ack = ack_seen;
    exp_mem(32'h5000, 1'b1, 4'd4);
    exp_mem(32'h5004, 1'b1, 4'd5);
    exp_mem(32'h5008, 1'b1, 4'd6);
    exp_mem(32'h500C, 1'b1, 4'd7);
    exp_ex(4'd0, 32'h5010);
    done_q.push_back(5);
    start_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'h5000, 16'h00F0);
    guard = 0;
    while (ack_seen < base_ack + 2 && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    check("acks_before_reset", 64'(ack_seen - base_ack), 64'd2);
    rst_n = 1'b0;
    mem_q.delete(); wb_q.delete(); ex_q.delete(); done_q.delete();
    ops--;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LDM IA after reset; base r9 is loaded, so no base writeback
    exp_mem(32'h6000, 1'b0, 4'd8);
    exp_mem(32'h6004, 1'b0, 4'd9);
    exp_mem(32'h6008, 1'b0, 4'd10);
    exp_mem(32'h600C, 1'b0, 4'd11);
    exp_wb(4'd8, 32'hA0A0_0000);
    exp_wb(4'd9, 32'hA0A0_0004);
    exp_wb(4'd10, 32'hA0A0_0008);
    exp_wb(4'd11, 32'hA0A0_000C);
    done_q.push_back(5);
    start_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32'h6000, 16'h0F00);
    wait_done("ldm_after_reset");

    // Address wrap, start pulse while busy, ack while idle
    exp_mem(32'hFFFF_FFFC, 1'b1, 4'd0);
    exp_mem(32'h0000_0000, 1'b1, 4'd1);
    exp_ex(4'd7, 32'h0000_0004);
    done_q.push_back(3);
    start_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 32'hFFFF_FFFC, 16'h0003);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done("wrap");
    force_ack = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_req", 64'(o_mem_req), 64'd0);
    force_ack = 1'b0;

    // STM DA
    exp_mem(32'h7FFC, 1'b1, 4'd0);
    exp_mem(32'h8000, 1'b1, 4'd2);
    exp_ex(4'd1, 32'h7FF8);
    done_q.push_back(3);
    start_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h8000, 16'h0005);
    wait_done("stm_da");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
